// File: rtl/neural_layer_engine.sv
// Sequential fully-connected layer engine: one registered MAC walks every neuron row over the input vector.
// Define NA_RELU_EN to build with ReLU activation; the default build uses identity activation.
module neural_layer_engine #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_count,
  input  logic [ADDR_W-1:0] out_count,
  input  logic [ADDR_W-1:0] neuron_ram_write_adr_ext,
  input  logic [DATA_W-1:0] neuron_ram_write_data_ext,
  input  logic              neuron_ram_wr_en_ext,
  input  logic [ADDR_W-1:0] weight_ram_write_adr_ext,
  input  logic [DATA_W-1:0] weight_ram_write_data_ext,
  input  logic              weight_ram_wr_en_ext,
  input  logic [ADDR_W-1:0] neuron_ram_read_adr_ext,
  output logic [DATA_W-1:0] neuron_ram_read_data_ext,
  output logic              busy,
  output logic              finished,
  output logic [ADDR_W-1:0] result_base_address,
  output logic [ADDR_W-1:0] result_word_count,
  output logic [2:0]        debug_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [DATA_W-1:0] nram [2**ADDR_W];
  logic [DATA_W-1:0] wram [2**ADDR_W];

  logic [2:0]               state;
  logic [ADDR_W-1:0]        n_in;
  logic [ADDR_W-1:0]        n_out;
  logic [ADDR_W-1:0]        base_r;
  logic [ADDR_W-1:0]        row_base;
  logic [ADDR_W-1:0]        idx_i;
  logic [ADDR_W-1:0]        idx_j;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic                     op_valid;
  logic signed [ACC_W-1:0]  acc;

  logic [DATA_W-1:0]          x_rd;
  logic [DATA_W-1:0]          w_rd;
  logic [DATA_W-1:0]          bias_rd;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    act_val;
  logic [DATA_W-1:0]          out_val;
  logic                       eng_we;
  logic [ADDR_W-1:0]          eng_adr;

  assign debug_state = state;

  assign x_rd     = nram[base_r + idx_i];
  assign w_rd     = wram[row_base + idx_i];
  assign bias_rd  = wram[row_base + n_in];
  assign prod     = op_a * op_b;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){bias_rd[DATA_W-1]}}, bias_rd};

  assign eng_we  = (state == S_WRITE);
  assign eng_adr = result_base_address + idx_j;

  // Read is combinational, so a same-cycle engine write is seen only after the edge.
  assign neuron_ram_read_data_ext = nram[neuron_ram_read_adr_ext];

  always_comb begin
    act_val = acc >>> FRAC_BITS;
`ifdef NA_RELU_EN
    if (act_val[ACC_W-1]) act_val = '0;
`endif
    if (act_val > SAT_MAX)      out_val = SAT_MAX[DATA_W-1:0];
    else if (act_val < SAT_MIN) out_val = SAT_MIN[DATA_W-1:0];
    else                        out_val = act_val[DATA_W-1:0];
  end

  // RAM contents survive reset; host writes are only honoured while the engine is idle.
  always_ff @(posedge clk) begin
    if (eng_we) nram[eng_adr] <= out_val;
    else if (neuron_ram_wr_en_ext && !busy)
      nram[neuron_ram_write_adr_ext] <= neuron_ram_write_data_ext;
  end

  always_ff @(posedge clk) begin
    if (weight_ram_wr_en_ext && !busy)
      wram[weight_ram_write_adr_ext] <= weight_ram_write_data_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_IDLE;
      busy                <= 1'b0;
      finished            <= 1'b0;
      result_base_address <= '0;
      result_word_count   <= '0;
      acc                 <= '0;
      n_in                <= '0;
      n_out               <= '0;
      base_r              <= '0;
      row_base            <= '0;
      idx_i               <= '0;
      idx_j               <= '0;
      op_a                <= '0;
      op_b                <= '0;
      op_valid            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_in                <= in_count;
            n_out               <= out_count;
            base_r              <= in_base;
            result_base_address <= in_base + in_count;
            result_word_count   <= out_count;
            row_base            <= '0;
            idx_i               <= '0;
            idx_j               <= '0;
            op_valid            <= 1'b0;
            if (out_count == '0) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              state    <= S_CLEAR;
              busy     <= 1'b1;
              finished <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          acc      <= bias_ext;
          idx_i    <= '0;
          op_valid <= 1'b0;
          state    <= (n_in == '0) ? S_DRAIN : S_MAC;
        end
        // Stage 1 registers the operand pair, stage 2 folds the previous pair into acc.
        S_MAC: begin
          op_a     <= x_rd;
          op_b     <= w_rd;
          op_valid <= 1'b1;
          if (op_valid) acc <= acc + prod_ext;
          if (idx_i == n_in - ADDR_W'(1)) state <= S_DRAIN;
          else                            idx_i <= idx_i + ADDR_W'(1);
        end
        S_DRAIN: begin
          if (op_valid) acc <= acc + prod_ext;
          op_valid <= 1'b0;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          row_base <= row_base + n_in + ADDR_W'(1);
          if (idx_j == n_out - ADDR_W'(1)) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else begin
            idx_j <= idx_j + ADDR_W'(1);
            state <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed bench for neural_layer_engine: table of layer runs plus hand-written reset and empty-layer sequences.
// Expectations for negative sums follow the NA_RELU_EN build setting.
module tb_neural_layer_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_base = '0, in_count = '0, out_count = '0;
  logic [7:0] n_wadr = '0, n_wdata = '0, w_wadr = '0, w_wdata = '0, n_radr = '0;
  logic       n_we = 1'b0, w_we = 1'b0;
  logic [7:0] n_rdata;
  logic       busy, finished;
  logic [7:0] rba, rwc;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef NA_RELU_EN
  localparam logic [7:0] NEG16 = 8'h00, NEG128 = 8'h00, NEG3 = 8'h00;
`else
  localparam logic [7:0] NEG16 = 8'hF0, NEG128 = 8'h80, NEG3 = 8'hFD;
`endif

  neural_layer_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .in_base(in_base), .in_count(in_count), .out_count(out_count),
    .neuron_ram_write_adr_ext(n_wadr), .neuron_ram_write_data_ext(n_wdata), .neuron_ram_wr_en_ext(n_we),
    .weight_ram_write_adr_ext(w_wadr), .weight_ram_write_data_ext(w_wdata), .weight_ram_wr_en_ext(w_we),
    .neuron_ram_read_adr_ext(n_radr), .neuron_ram_read_data_ext(n_rdata),
    .busy(busy), .finished(finished),
    .result_base_address(rba), .result_word_count(rwc), .debug_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       base;
    logic [7:0]       n_in;
    logic [7:0]       n_out;
    logic [0:3][7:0]  x;
    logic [0:9][7:0]  w;
    logic [0:1][7:0]  r;
    logic [7:0]       rba;
    logic [7:0]       cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write tasks are entered away from an edge and return #1 after the edge that performed the write.
  task automatic host_nwr(input logic [7:0] a, input logic [7:0] d);
    n_wadr = a; n_wdata = d; n_we = 1'b1;
    @(posedge clk); #1;
    n_we = 1'b0;
  endtask

  task automatic host_wwr(input logic [7:0] a, input logic [7:0] d);
    w_wadr = a; w_wdata = d; w_we = 1'b1;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    n_radr = a;
    #1;
    d = n_rdata;
  endtask

  // Edge 1 is the edge that samples start; returns the edge at which finished was first seen high.
  task automatic run(input logic [7:0] b, input logic [7:0] ni, input logic [7:0] no, output int edges);
    @(negedge clk);
    in_base = b; in_count = ni; out_count = no; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!finished && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!finished) $display("FAIL run_timeout: got finished=0 expected finished=1 within 300 edges");
  endtask

  initial begin
    int edges;
    logic [7:0] d;
    logic [7:0] a;

    vecs[0] = '{base:8'd0, n_in:8'd4, n_out:8'd1, x:{8'd2,8'd3,8'd7,8'd4},
                w:{8'd1,8'd1,8'd1,8'd1,8'd1,40'h0}, r:{8'd17,8'd0}, rba:8'd4, cyc:8'd8};
    vecs[1] = '{base:8'd0, n_in:8'd4, n_out:8'd1, x:{8'd2,8'd3,8'd7,8'd4},
                w:{8'hFF,8'hFF,8'hFF,8'hFF,8'd0,40'h0}, r:{NEG16,8'd0}, rba:8'd4, cyc:8'd8};
    vecs[2] = '{base:8'd0, n_in:8'd2, n_out:8'd1, x:{8'd100,8'd100,16'h0},
                w:{8'd100,8'd100,8'd0,56'h0}, r:{8'd127,8'd0}, rba:8'd2, cyc:8'd6};
    vecs[3] = '{base:8'd0, n_in:8'd2, n_out:8'd1, x:{8'd100,8'd100,16'h0},
                w:{8'h9C,8'h9C,8'd0,56'h0}, r:{NEG128,8'd0}, rba:8'd2, cyc:8'd6};
    vecs[4] = '{base:8'd10, n_in:8'd0, n_out:8'd2, x:32'h0,
                w:{8'd5,8'hFD,64'h0}, r:{8'd5,NEG3}, rba:8'd10, cyc:8'd7};
    vecs[5] = '{base:8'd20, n_in:8'd3, n_out:8'd2, x:{8'd1,8'hFE,8'd3,8'd0},
                w:{8'd2,8'd3,8'd4,8'hFF,8'hFF,8'd1,8'd1,8'd10,16'h0}, r:{8'd7,8'd10}, rba:8'd23, cyc:8'd13};
    vecs[6] = '{base:8'd254, n_in:8'd2, n_out:8'd1, x:{8'd5,8'd6,16'h0},
                w:{8'd3,8'd2,8'hEC,56'h0}, r:{8'd7,8'd0}, rba:8'd0, cyc:8'd6};

    #2;
    check("reset_busy", busy, 0);
    check("reset_finished", finished, 0);
    check("reset_rba", rba, 0);
    check("reset_rwc", rwc, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      for (int q = 0; q < int'(vecs[k].n_out); q++) begin
        a = vecs[k].rba + 8'(q);
        host_nwr(a, 8'h5A);
      end
      for (int q = 0; q < int'(vecs[k].n_out) * (int'(vecs[k].n_in) + 1); q++)
        host_wwr(8'(q), vecs[k].w[q]);
      for (int q = 0; q < int'(vecs[k].n_in); q++) begin
        a = vecs[k].base + 8'(q);
        host_nwr(a, vecs[k].x[q]);
      end
      run(vecs[k].base, vecs[k].n_in, vecs[k].n_out, edges);
      check($sformatf("v%0d_finish_edge", k), edges, vecs[k].cyc);
      check($sformatf("v%0d_busy", k), busy, 0);
      check($sformatf("v%0d_rba", k), rba, vecs[k].rba);
      check($sformatf("v%0d_rwc", k), rwc, vecs[k].n_out);
      for (int q = 0; q < int'(vecs[k].n_out); q++) begin
        a = vecs[k].rba + 8'(q);
        rd(a, d);
        check($sformatf("v%0d_result%0d", k, q), d, vecs[k].r[q]);
      end
    end

    // Empty layer started straight from DONE.
    run(8'd7, 8'd3, 8'd0, edges);
    check("empty_finish_edge", edges, 1);
    check("empty_busy", busy, 0);
    check("empty_rwc", rwc, 0);
    check("empty_rba", rba, 10);

    // Reset in the middle of a two-neuron run; host writes inside the run must be dropped.
    for (int q = 0; q < 8; q++) host_wwr(8'(q), vecs[5].w[q]);
    host_nwr(8'd23, 8'h5A);
    host_nwr(8'd24, 8'h5A);
    host_nwr(8'd50, 8'h11);
    @(negedge clk);
    in_base = 8'd20; in_count = 8'd3; out_count = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mid_busy_after_start", busy, 1);
    host_nwr(8'd50, 8'hAB);
    host_wwr(8'd0, 8'h7F);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_finished", finished, 0);
    check("mid_reset_rba", rba, 0);
    check("mid_reset_rwc", rwc, 0);
    check("mid_reset_state", dbg_state, 0);
    rd(8'd50, d);
    check("dropped_neuron_write", d, 8'h11);
    rd(8'd23, d);
    check("no_early_result", d, 8'h5A);
    @(negedge clk);
    reset = 1'b1;
    run(8'd20, 8'd3, 8'd2, edges);
    check("rerun_finish_edge", edges, 13);
    rd(8'd23, d);
    check("rerun_result0", d, 8'd7);
    rd(8'd24, d);
    check("rerun_result1", d, 8'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
